// File: rtl/co_ri_mixer_if.sv
// Handshake and data bundle for co_ri_mixer.
// Upstream (TX interpolator) is the master and the mixer is the slave.
// CO_RI_MIXER_SIDEBAND_SEL_EN adds the lsb_sel sideband select line.
interface co_ri_mixer_if #(
  parameter int DSZ = 16
);
  logic                  in_valid;
  logic                  in_ready;
  logic signed [DSZ-1:0] in_i;
  logic signed [DSZ-1:0] in_q;
  logic signed [DSZ-1:0] lo_i;
  logic signed [DSZ-1:0] lo_q;
  logic signed [DSZ-1:0] out;
  logic                  out_valid;
`ifdef CO_RI_MIXER_SIDEBAND_SEL_EN
  logic                  lsb_sel;

  modport master (
    output in_valid, in_i, in_q, lo_i, lo_q, lsb_sel,
    input  in_ready, out, out_valid
  );

  modport slave (
    input  in_valid, in_i, in_q, lo_i, lo_q, lsb_sel,
    output in_ready, out, out_valid
  );
`else
  modport master (
    output in_valid, in_i, in_q, lo_i, lo_q,
    input  in_ready, out, out_valid
  );

  modport slave (
    input  in_valid, in_i, in_q, lo_i, lo_q,
    output in_ready, out, out_valid
  );
`endif
endinterface

// File: rtl/co_ri_mixer.sv
// Complex-to-real upconversion mixer: out = Re{(I + jQ)(LOi + jLOq)}
// = I*LOi - Q*LOq in Q1.(DSZ-1), one shared multiplier, round-half-up at
// weight 2^(DSZ-1), symmetric saturation. One sample every 5 clocks,
// accept-to-strobe latency of 4 clocks.
// Optional: CO_RI_MIXER_SIDEBAND_SEL_EN adds a per-sample lsb_sel that
// flips the Q term sign (lower sideband).
module co_ri_mixer #(
  parameter int DSZ = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  co_ri_mixer_if.slave bus
);

  localparam int PW = 2 * DSZ;      // full product width
  localparam int SW = 2 * DSZ + 1;  // sum width, holds (-1*-1) - (-1*+1)
  localparam int RW = DSZ + 3;      // rounding field width

  typedef enum logic [2:0] {
    IDLE,
    MUL_I,
    MUL_Q,
    SUM,
    RND
  } state_t;

  state_t                state_q;

  // Sample/LO buffers captured at accept
  logic signed [DSZ-1:0] in_i_q;
  logic signed [DSZ-1:0] in_q_q;
  logic signed [DSZ-1:0] lo_i_q;
  logic signed [DSZ-1:0] lo_q_q;
`ifdef CO_RI_MIXER_SIDEBAND_SEL_EN
  logic                  lsb_sel_q;
`endif

  // Datapath registers
  logic signed [PW-1:0]  prod_q;
  logic signed [PW-1:0]  acc_q;
  logic        [SW-1:0]  sum_q;
  logic signed [DSZ-1:0] out_q;
  logic                  out_valid_q;

  // Combinational datapath
  logic signed [DSZ-1:0] mul_a;
  logic signed [DSZ-1:0] mul_b;
  logic signed [PW-1:0]  mul_p;
  logic        [SW-1:0]  sum_d;
  logic        [RW-1:0]  rnd;
  logic        [DSZ+1:0] rnd_sh;
  logic signed [DSZ-1:0] out_d;
  logic                  ovf;
  logic                  unused_lsbs;

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;

  // Shared multiplier: Q operands only in MUL_Q, I operands otherwise
  always_comb begin
    mul_a = in_i_q;
    mul_b = lo_i_q;
    if (state_q == MUL_Q) begin
      mul_a = in_q_q;
      mul_b = lo_q_q;
    end
    mul_p = PW'(mul_a) * PW'(mul_b);
  end

  // Combine I and Q terms at full precision; sign-extend both to SW bits
  always_comb begin
    sum_d = {acc_q[PW-1], acc_q} - {prod_q[PW-1], prod_q};
`ifdef CO_RI_MIXER_SIDEBAND_SEL_EN
    if (lsb_sel_q)
      sum_d = {acc_q[PW-1], acc_q} + {prod_q[PW-1], prod_q};
`endif
  end

  // Round half toward +inf at weight 2^(DSZ-1), then clip to DSZ bits.
  // rnd keeps one bit below the output LSB; adding 1 there and dropping it
  // gives floor(x + 0.5). Overflow when the top three bits of the shifted
  // value disagree.
  always_comb begin
    rnd    = sum_q[SW-1:DSZ-2] + {{(RW-1){1'b0}}, 1'b1};
    rnd_sh = rnd[RW-1:1];
    ovf    = !((rnd_sh[DSZ+1:DSZ-1] == 3'b000) || (rnd_sh[DSZ+1:DSZ-1] == 3'b111));
    out_d  = rnd_sh[DSZ-1:0];
    if (ovf)
      out_d = rnd_sh[DSZ+1] ? {1'b1, {(DSZ-1){1'b0}}} : {1'b0, {(DSZ-1){1'b1}}};
  end

  // Bits below the rounding point carry no information after rounding
  assign unused_lsbs = ^{sum_q[DSZ-3:0], rnd[0]};

  // Sequencer and datapath registers; out_valid is a one-cycle strobe from RND
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      in_i_q      <= '0;
      in_q_q      <= '0;
      lo_i_q      <= '0;
      lo_q_q      <= '0;
`ifdef CO_RI_MIXER_SIDEBAND_SEL_EN
      lsb_sel_q   <= 1'b0;
`endif
      prod_q      <= '0;
      acc_q       <= '0;
      sum_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            in_i_q    <= bus.in_i;
            in_q_q    <= bus.in_q;
            lo_i_q    <= bus.lo_i;
            lo_q_q    <= bus.lo_q;
`ifdef CO_RI_MIXER_SIDEBAND_SEL_EN
            lsb_sel_q <= bus.lsb_sel;
`endif
            state_q   <= MUL_I;
          end
        end
        MUL_I: begin
          prod_q  <= mul_p;
          state_q <= MUL_Q;
        end
        MUL_Q: begin
          acc_q   <= prod_q;
          prod_q  <= mul_p;
          state_q <= SUM;
        end
        SUM: begin
          sum_q   <= sum_d;
          state_q <= RND;
        end
        RND: begin
          out_q       <= out_d;
          out_valid_q <= 1'b1;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_co_ri_mixer.sv
// Self-checking bench for co_ri_mixer: directed vector table, handshake and
// reset sequences, and a back-to-back random run against a reference model.
module tb_co_ri_mixer;
  localparam int DSZ = 16;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  co_ri_mixer_if #(.DSZ(DSZ)) m ();
  co_ri_mixer #(.DSZ(DSZ)) dut (.clk(clk), .reset_n(reset_n), .bus(m));

  typedef struct {
    logic signed [15:0] i, q, li, lq;
    bit                 lsb;
    logic signed [15:0] e;
    string              name;
  } vec_t;

  vec_t               tbl[$];
  int                 n_chk = 0, n_fail = 0;
  int                 cyc = 0, n_strobe = 0;
  logic signed [15:0] exp_q[$];
  int                 acc_cyc[$];
  logic signed [15:0] cur_exp = '0;
  bit                 b2b = 1'b0;
  int                 last_acc = -1;

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic signed [15:0] model(input logic signed [15:0] i, q, li, lq,
                                               input bit lsb);
    longint p1, p2, s, r;
    p1 = longint'(i) * longint'(li);
    p2 = longint'(q) * longint'(lq);
    s  = lsb ? p1 + p2 : p1 - p2;
    r  = (s + 16384) >>> 15;
    if (r > 32767) r = 32767;
    else if (r < -32768) r = -32768;
    return 16'(r);
  endfunction

  task automatic set_inputs(input logic signed [15:0] i, q, li, lq, input bit lsb);
    m.in_i = i; m.in_q = q; m.lo_i = li; m.lo_q = lq;
`ifdef CO_RI_MIXER_SIDEBAND_SEL_EN
    m.lsb_sel = lsb;
`endif
  endtask

  // Wait for ready, present one sample for exactly one accepting edge
  task automatic drive(input logic signed [15:0] i, q, li, lq, input bit lsb,
                       input logic signed [15:0] e);
    bit got = 1'b0;
    for (int c = 0; c < 50 && !got; c++) begin
      @(negedge clk);
      if (m.in_ready) got = 1'b1;
    end
    if (!got) begin
      check("ready_timeout", 0, 1);
      return;
    end
    set_inputs(i, q, li, lq, lsb);
    cur_exp    = e;
    m.in_valid = 1'b1;
    @(negedge clk);
    m.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int c = 0; c < 50 && exp_q.size() != 0; c++) @(negedge clk);
    if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
  endtask

  // Accept monitor: record expected result and accept edge number
  always @(posedge clk) begin
    if (reset_n && m.in_valid && m.in_ready) begin
      exp_q.push_back(cur_exp);
      acc_cyc.push_back(cyc + 1);
      if (b2b && last_acc >= 0) check("b2b_spacing", cyc + 1 - last_acc, 5);
      last_acc = cyc + 1;
    end
    cyc <= cyc + 1;
  end

  // Output monitor: every strobe must match a pending accept, 4 edges later
  always @(negedge clk) begin
    if (reset_n && m.out_valid) begin
      n_strobe++;
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL stale_strobe: got out_valid=1 out=%0d expected no strobe", m.out);
      end else begin
        check("out", m.out, exp_q.pop_front());
        check("latency", cyc - acc_cyc.pop_front(), 4);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, sent;
    logic signed [15:0] ri, rq, rli, rlq;
    bit rl;

    tbl.push_back('{16384, 0, 16384, 0, 1'b0, 8192, "basic"});
    tbl.push_back('{0, 16384, 0, 16384, 1'b0, -8192, "quad"});
    tbl.push_back('{1, 0, 16384, 0, 1'b0, 1, "rnd_half_up"});
    tbl.push_back('{1, 0, 16383, 0, 1'b0, 0, "rnd_below_half"});
    tbl.push_back('{-1, 0, 16384, 0, 1'b0, 0, "rnd_neg_half"});
    tbl.push_back('{3, 0, 16384, 0, 1'b0, 2, "rnd_1p5"});
    tbl.push_back('{-32768, 32767, -32768, -32768, 1'b0, 32767, "sat_pos"});
    tbl.push_back('{-32768, 32767, 32767, 32767, 1'b0, -32768, "sat_neg"});
`ifdef CO_RI_MIXER_SIDEBAND_SEL_EN
    tbl.push_back('{0, 16384, 0, 16384, 1'b1, 8192, "quad_lsb"});
    tbl.push_back('{-32768, 32767, -32768, -32768, 1'b1, 1, "sat_lsb"});
`endif

    reset_n    = 1'b0;
    m.in_valid = 1'b0;
    set_inputs(0, 0, 0, 0, 1'b0);
    repeat (2) @(negedge clk);
    check("rst_out", m.out, 0);
    check("rst_out_valid", m.out_valid, 0);
    check("rst_in_ready", m.in_ready, 1);
    reset_n = 1'b1;

    // Handshake: in_ready low for the 4 cycles after an accept
    drive(16384, 0, 16384, 0, 1'b0, 8192);
    for (int c = 0; c < 4; c++) begin
      check("ready_low", m.in_ready, 0);
      @(negedge clk);
    end
    check("ready_back", m.in_ready, 1);
    wait_drain();

    // Directed vectors
    foreach (tbl[k]) begin
      drive(tbl[k].i, tbl[k].q, tbl[k].li, tbl[k].lq, tbl[k].lsb, tbl[k].e);
      wait_drain();
    end

    // Reset in MUL_Q aborts the sample, no stale strobe afterwards
    s0 = n_strobe;
    drive(16384, 0, 16384, 0, 1'b0, 8192);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("abort_out", m.out, 0);
    check("abort_out_valid", m.out_valid, 0);
    check("abort_in_ready", m.in_ready, 1);
    exp_q.delete();
    acc_cyc.delete();
    @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    check("abort_no_strobe", n_strobe - s0, 0);
    check("abort_out_hold", m.out, 0);

    // Back-to-back random vectors; in_valid held high then toggled while busy
    b2b      = 1'b1;
    last_acc = -1;
    s0       = n_strobe;
    sent     = 0;
    for (int c = 0; c < 200 && sent < 8; c++) begin
      @(negedge clk);
      ri  = 16'($urandom); rq  = 16'($urandom);
      rli = 16'($urandom); rlq = 16'($urandom);
`ifdef CO_RI_MIXER_SIDEBAND_SEL_EN
      rl  = 1'($urandom);
`else
      rl  = 1'b0;
`endif
      set_inputs(ri, rq, rli, rlq, rl);
      cur_exp = model(ri, rq, rli, rlq, rl);
      if (m.in_ready) begin
        m.in_valid = 1'b1;
        sent++;
      end else begin
        m.in_valid = (sent < 4) ? 1'b1 : 1'($urandom_range(0, 1));
      end
    end
    @(negedge clk);
    m.in_valid = 1'b0;
    check("b2b_sent", sent, 8);
    wait_drain();
    repeat (6) @(negedge clk);
    check("b2b_strobes", n_strobe - s0, 8);
    b2b = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
